// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM access controller.
package sram_pkg;

  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_STROBE,
    WR_HOLD,
    RD_STROBE,
    DONE
  } sram_state_t;

endpackage

// File: rtl/sram_access_iface_if.sv
// Requester-side handshake between the datapath (master) and the SRAM controller (slave).
interface sram_access_iface_if;
  import sram_pkg::*;

  logic                 start;
  logic                 writemode;
  logic [ADDR_BITS-1:0] i_address;
  logic [DATA_BITS-1:0] i_w_data;
  logic [DATA_BITS-1:0] i_r_data;
  logic                 io_done;

  modport master (
    output start, writemode, i_address, i_w_data,
    input  i_r_data, io_done
  );

  modport slave (
    input  start, writemode, i_address, i_w_data,
    output i_r_data, io_done
  );

endinterface

// File: rtl/sram_access_iface.sv
// Single-word access controller: turns a one-shot request into timed strobes
// for an asynchronous SRAM and returns read data with a one-cycle done pulse.
module sram_access_iface
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sram_access_iface_if.slave   req,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] w_data,
  input  logic [DATA_BITS-1:0] r_data
);

  localparam int                 CNT_BITS = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WAIT_CYCLES - 1);

  sram_state_t         state;
  sram_state_t         state_nxt;
  logic [CNT_BITS-1:0] wait_cnt;
  logic                start_q;
  logic                request;
  logic                cnt_zero;

  // Only a rising edge seen while idle starts an access; edges while busy are consumed.
  assign request  = req.start & ~start_q & (state == IDLE);
  assign cnt_zero = (wait_cnt == '0);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:      if (request) state_nxt = req.writemode ? WR_STROBE : RD_STROBE;
      WR_STROBE: if (cnt_zero) state_nxt = WR_HOLD;
      WR_HOLD:   state_nxt = DONE;
      RD_STROBE: if (cnt_zero) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Strobes and done are decoded from the next state so they are registered
  // and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      wait_cnt     <= '0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      req.io_done  <= 1'b0;
      address      <= '0;
      w_data       <= '0;
      req.i_r_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_nxt;
      start_q      <= req.start;
      write_enable <= (state_nxt == WR_STROBE);
      read_enable  <= (state_nxt == RD_STROBE);
      req.io_done  <= (state_nxt == DONE);

      if (request) begin
        address  <= req.i_address;
        w_data   <= req.i_w_data;
        wait_cnt <= CNT_LOAD;
      end else if ((state == WR_STROBE || state == RD_STROBE) && !cnt_zero) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      // Last strobe clock: the SRAM output has settled for the full strobe width.
      if (state == RD_STROBE && cnt_zero) begin
        req.i_r_data <= r_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_iface.sv
// Directed bench for sram_access_iface with a behavioural asynchronous SRAM.
module tb_sram_access_iface;
  import sram_pkg::*;

  localparam int W = 2;

  logic                 clk;
  logic                 n_rst;
  logic                 read_enable;
  logic                 write_enable;
  logic [ADDR_BITS-1:0] address;
  logic [DATA_BITS-1:0] w_data;
  logic [DATA_BITS-1:0] r_data;

  sram_access_iface_if rq ();

  sram_access_iface #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (rq),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .w_data       (w_data),
    .r_data       (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: filled with a known pattern on the first clock, written on the strobe.
  logic [DATA_BITS-1:0] mem [0:65535];
  logic                 mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE, i[15:0]};
      mem_ready <= 1'b1;
    end else if (write_enable) begin
      mem[address] <= w_data;
    end
  end

  // Undriven bus modelled as a junk pattern so a mistimed latch is visible.
  assign r_data = read_enable ? mem[address] : 32'hDEAD_BEEF;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  logic overlap  = 1'b0;

  always @(negedge clk) begin
    if (rq.io_done) done_cnt++;
    if (write_enable && read_enable) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One access. start_mask[k] is the start level driven after the k-th
  // negedge following the request edge; k indexes clocks after that edge.
  task automatic run_access(input string tag, input logic wm, input logic [15:0] a,
                            input logic [31:0] d, input logic [15:0] start_mask,
                            input logic [31:0] rexp);
    logic [15:0] we_t, re_t, dn_t, we_e, re_e, dn_e;
    int kd;
    kd = wm ? W + 2 : W + 1;
    we_t = '0; re_t = '0; dn_t = '0; we_e = '0; re_e = '0; dn_e = '0;
    for (int k = 1; k < 16; k++) begin
      we_e[k] = wm && (k <= W);
      re_e[k] = !wm && (k <= W);
      dn_e[k] = (k == kd);
    end
    @(negedge clk);
    rq.writemode = wm;
    rq.i_address = a;
    rq.i_w_data  = d;
    rq.start     = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      we_t[k] = write_enable;
      re_t[k] = read_enable;
      dn_t[k] = rq.io_done;
      if (k == 1) begin
        check({tag, "_addr"}, address, a);
        if (wm) check({tag, "_wdata"}, w_data, d);
        rq.i_address = ~a;
        rq.i_w_data  = ~d;
      end
      if (wm && k == W + 1) begin
        check({tag, "_hold_addr"}, address, a);
        check({tag, "_hold_wdata"}, w_data, d);
      end
      if (k == kd) check({tag, "_rdata"}, rq.i_r_data, rexp);
      rq.start = start_mask[k];
    end
    check({tag, "_we_trace"}, we_t, we_e);
    check({tag, "_re_trace"}, re_t, re_e);
    check({tag, "_done_trace"}, dn_t, dn_e);
    check({tag, "_idle_addr"}, address, a);
    rq.start = 1'b0;
  endtask

  int d0;

  initial begin
    n_rst        = 1'b0;
    rq.start     = 1'b0;
    rq.writemode = 1'b0;
    rq.i_address = '0;
    rq.i_w_data  = '0;

    @(posedge clk);
    #1;
    check("rst_we", write_enable, 1'b0);
    check("rst_re", read_enable, 1'b0);
    check("rst_done", rq.io_done, 1'b0);
    check("rst_addr", address, 16'h0);
    check("rst_wdata", w_data, 32'h0);
    check("rst_rdata", rq.i_r_data, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_access("wr1", 1'b1, 16'h0001, 32'h0000_00AF, 16'h0006, 32'h0);
    check("mem1", mem[16'h0001], 32'h0000_00AF);
    run_access("rd1", 1'b0, 16'h0001, 32'h0, 16'h0000, 32'h0000_00AF);
    run_access("long", 1'b1, 16'h0003, 32'h1234_5678, 16'h001E, 32'h0000_00AF);
    run_access("busy", 1'b0, 16'h0003, 32'h0, 16'h000C, 32'h1234_5678);
    run_access("donedge", 1'b1, 16'h0004, 32'hCAFE_F00D, 16'h0030, 32'h1234_5678);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    rq.writemode = 1'b1;
    rq.i_address = 16'h0002;
    rq.i_w_data  = 32'h0000_0055;
    rq.start     = 1'b1;
    @(negedge clk);
    rq.start = 1'b0;
    check("abort_pre_we", write_enable, 1'b1);
    d0 = done_cnt;
    #2 n_rst = 1'b0;
    #1;
    check("abort_we", write_enable, 1'b0);
    check("abort_done", rq.io_done, 1'b0);
    check("abort_addr", address, 16'h0);
    check("abort_wdata", w_data, 32'h0);
    check("abort_rdata", rq.i_r_data, 32'h0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    check("abort_idle_we", write_enable, 1'b0);

    run_access("rd_after", 1'b0, 16'h0001, 32'h0, 16'h0000, 32'h0000_00AF);
    run_access("wr_top", 1'b1, 16'hFFFF, 32'hA5A5_5A5A, 16'h0000, 32'h0000_00AF);
    run_access("rd_zero", 1'b0, 16'h0000, 32'h0, 16'h0000, 32'hC0DE_0000);
    check("mem_top", mem[16'hFFFF], 32'hA5A5_5A5A);
    check("mem3", mem[16'h0003], 32'h1234_5678);
    check("no_overlap", overlap, 1'b0);
    check("done_total", done_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
